// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side memory responder: MMIO window base,
// register offsets and STATUS register bit layout.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [3:0] LED_OFS  = 4'h0;
    localparam logic [3:0] TX_OFS   = 4'h4;
    localparam logic [3:0] STAT_OFS = 4'h8;
    localparam logic [3:0] CYC_OFS  = 4'hC;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    // Assemble the STATUS read value from its fields
    function automatic logic [31:0] pack_status(input logic [3:0] cnt,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] v;
        v = '0;
        v[ST_CNT_LSB +: 4] = cnt;
        v[ST_OVF]          = ovf;
        v[ST_FULL]         = full;
        v[ST_EMPTY]        = empty;
        return v;
    endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Transmit FIFO: registered head (no fall-through), power-of-two depth,
// simultaneous push/pop allowed; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [31:0]                     push_data,
    input  logic                            pop,
    output logic [31:0]                     head,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            full,
    output logic                            empty
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Storage array; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Memory-stage data responder: word RAM below 0x8000_0000 plus an MMIO
// window holding LEDs, a TX FIFO with sticky overflow, and a cycle counter.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  leds
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_leds;
    logic [31:0]   r_cycles;
    logic          r_ovf;

    logic          w_ram_sel;
    logic          w_mmio_sel;
    logic [AW-1:0] w_ram_idx;
    logic [3:0]    w_ofs;
    logic          w_led_wr;
    logic          w_tx_wr;
    logic          w_stat_wr;
    logic          w_cyc_wr;
    logic          w_pop;
    logic          w_ovf_evt;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_unused;

    assign w_ram_sel  = !a[31] && (a[30:2+AW] == '0);
    assign w_mmio_sel = (a[31:4] == MMIO_BASE[31:4]);
    assign w_ram_idx  = a[2 +: AW];
    assign w_ofs      = {a[3:2], 2'b00};
    assign w_unused   = ^a[1:0];

    assign w_led_wr   = we && w_mmio_sel && (w_ofs == LED_OFS);
    assign w_tx_wr    = we && w_mmio_sel && (w_ofs == TX_OFS);
    assign w_stat_wr  = we && w_mmio_sel && (w_ofs == STAT_OFS);
    assign w_cyc_wr   = we && w_mmio_sel && (w_ofs == CYC_OFS);

    assign tx_valid   = !w_empty;
    assign w_pop      = tx_valid && tx_ready;
    assign w_ovf_evt  = w_tx_wr && w_full && !w_pop;
    assign leds       = r_leds;

    tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_tx_wr),
        .push_data (wd),
        .pop       (w_pop),
        .head      (tx_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we && w_ram_sel && !reset) begin
            r_ram[w_ram_idx] <= wd;
        end
    end

    // LED register, free-running cycle counter and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds   <= '0;
            r_cycles <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_led_wr) r_leds <= wd[7:0];
            if (w_cyc_wr) r_cycles <= wd;
            else          r_cycles <= r_cycles + 32'd1;
            if (w_ovf_evt)                r_ovf <= 1'b1;
            else if (w_stat_wr && wd[ST_OVF]) r_ovf <= 1'b0;
        end
    end

    // Zero-latency read mux; unmapped addresses read as zero
    always_comb begin
        rd = '0;
        if (w_ram_sel) begin
            rd = r_ram[w_ram_idx];
        end else if (w_mmio_sel) begin
            case (w_ofs)
                LED_OFS:  rd = {24'b0, r_leds};
                STAT_OFS: rd = pack_status(4'(w_count), r_ovf, w_full, w_empty);
                CYC_OFS:  rd = r_cycles;
                default:  rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;
    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  leds;

    int vectors;
    int miscompares;

    localparam logic [31:0] A_LED  = 32'h8000_0000;
    localparam logic [31:0] A_TX   = 32'h8000_0004;
    localparam logic [31:0] A_STAT = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_000C;

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .wd       (wd),
        .we       (we),
        .rd       (rd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .leds     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic set_addr(input logic [31:0] addr);
        a  = addr;
        we = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (leds !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_leds: got %h want 00", leds);
        end
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
        end
        set_addr(A_STAT);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL reset_status: got %h want 00000001", rd);
        end
        set_addr(A_CYC);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_cycles_hold: got %h want 00000000", rd);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL first_increment: got %h want 00000001", rd);
        end
    endtask

    task automatic test_ram();
        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        set_addr(32'h0000_0013);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL ram_readback: got %h want deadbeef", rd);
        end
        do_write(32'h0000_0000, 32'h1234_5678);
        do_write(32'h0000_00FC, 32'hCAFE_F00D);
        do_write(32'h0000_0100, 32'hBAD0_BAD0);
        set_addr(32'h0000_0100);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL ram_out_of_range: got %h want 00000000", rd);
        end
        set_addr(32'h0000_0000);
        vectors++;
        if (rd !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL ram_no_alias: got %h want 12345678", rd);
        end
        set_addr(32'h0000_00FC);
        vectors++;
        if (rd !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL ram_top_word: got %h want cafef00d", rd);
        end
    endtask

    task automatic test_led_reset();
        do_write(A_LED, 32'h0000_01A5);
        vectors++;
        if (leds !== 8'hA5) begin
            miscompares++;
            $display("FAIL led_write: got %h want a5", leds);
        end
        set_addr(A_LED);
        vectors++;
        if (rd !== 32'h0000_00A5) begin
            miscompares++;
            $display("FAIL led_read: got %h want 000000a5", rd);
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (leds !== 8'h00) begin
            miscompares++;
            $display("FAIL led_async_reset: got %h want 00", leds);
        end
        reset = 1'b0;
        set_addr(32'h0000_0010);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL ram_retained: got %h want deadbeef", rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fifo_overflow();
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) do_write(A_TX, 32'(i));
        set_addr(A_STAT);
        vectors++;
        if (rd !== 32'h0000_0046) begin
            miscompares++;
            $display("FAIL fifo_full_ovf_status: got %h want 00000046", rd);
        end
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 32'h1) begin
            miscompares++;
            $display("FAIL fifo_head: got valid=%b data=%h want valid=1 data=00000001", tx_valid, tx_data);
        end
        set_addr(A_TX);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL txdata_read: got %h want 00000000", rd);
        end
        do_write(A_STAT, 32'h0000_0004);
        set_addr(A_STAT);
        vectors++;
        if (rd !== 32'h0000_0042) begin
            miscompares++;
            $display("FAIL ovf_clear: got %h want 00000042", rd);
        end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] exp_q [4];
        exp_q[0] = 32'd2;
        exp_q[1] = 32'd3;
        exp_q[2] = 32'd4;
        exp_q[3] = 32'd9;
        tx_ready = 1'b1;
        do_write(A_TX, 32'd9);
        tx_ready = 1'b0;
        set_addr(A_STAT);
        vectors++;
        if (rd !== 32'h0000_0042) begin
            miscompares++;
            $display("FAIL push_pop_at_full: got %h want 00000042", rd);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                miscompares++;
                $display("FAIL drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp_q[i]);
            end
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        set_addr(A_STAT);
        vectors++;
        if (rd !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL drained_status: got %h want 00000001", rd);
        end
        vectors++;
        if (tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drained_valid: got %b want 0", tx_valid);
        end
    endtask

    task automatic test_cycles();
        logic [31:0] exp_c [3];
        exp_c[0] = 32'hFFFF_FFFE;
        exp_c[1] = 32'hFFFF_FFFF;
        exp_c[2] = 32'h0000_0000;
        do_write(A_CYC, 32'hFFFF_FFFE);
        set_addr(A_CYC);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rd !== exp_c[i]) begin
                miscompares++;
                $display("FAIL cycles_%0d: got %h want %h", i, rd, exp_c[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_unmapped();
        do_write(A_LED, 32'h0000_003C);
        do_write(A_TX, 32'h0000_0077);
        do_write(32'h8000_0010, 32'hFFFF_FFFF);
        do_write(32'hC000_0008, 32'hFFFF_FFFF);
        vectors++;
        if (leds !== 8'h3C) begin
            miscompares++;
            $display("FAIL unmapped_leds: got %h want 3c", leds);
        end
        set_addr(A_STAT);
        vectors++;
        if (rd !== 32'h0000_0010) begin
            miscompares++;
            $display("FAIL unmapped_status: got %h want 00000010", rd);
        end
        vectors++;
        if (tx_data !== 32'h77) begin
            miscompares++;
            $display("FAIL unmapped_fifo_head: got %h want 00000077", tx_data);
        end
        set_addr(32'h8000_0010);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_read: got %h want 00000000", rd);
        end
        set_addr(32'hC000_000C);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_high_read: got %h want 00000000", rd);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        a           = '0;
        wd          = '0;
        we          = 1'b0;
        tx_ready    = 1'b0;
        test_reset();
        test_ram();
        test_led_reset();
        test_fifo_overflow();
        test_push_pop_full();
        test_cycles();
        test_unmapped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
